memory_arbiter_ctrl: RTL
========================

Name: memory_arbiter_ctrl

Overview:
- Memory-side responder to the CPU request unit.
- Accepts instruction fetch (iREN) and data read/write (dREN/dWEN) requests and serialises them onto one single-ported RAM interface.
- Returns ihit/dhit with registered load data.
- Sits between the datapath request unit and the RAM model/bus.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of store/load ports.
- TIMEOUT, 255, max cycles a granted access may wait for RAM ACCESS before the block enters ERR.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- ihit  out  1  one-cycle pulse: instruction access complete, iload valid.
- iload  out  DATA_W  fetched instruction.
- dhit  out  1  one-cycle pulse: data access complete, dload valid after a read.
- dload  out  DATA_W  loaded data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- merr  out  1  sticky memory error flag.

Behaviour:
- All state updates on posedge CLK. Reset is synchronous: nRST=0 sampled at an edge forces the reset values below, including mid-access. The in-flight RAM access is abandoned and no hit is issued.
- Reset values: state IDLE; ihit, dhit, ramREN, ramWEN, merr = 0; iload, dload, ramaddr, ramstore = 0; timeout counter 0; last_grant = INSTR.
- States and transitions:
  - IDLE: data request = dREN|dWEN.
    - Data request only: grant data, go to DACC.
    - iREN only: grant instruction, go to IACC.
    - Both pending: grant the side opposite last_grant. Data wins after an instruction grant, instruction wins after a data grant; this prevents starvation.
    - On grant, capture the request into internal registers: addr, store data, write flag (dWEN has priority over dREN if both high), and the granted side. Update last_grant and clear the counter.
  - DACC/IACC:
    - ramaddr/ramstore/ramREN/ramWEN are driven only from the captured registers. ramWEN=1 only for a data write; ramREN=1 otherwise.
    - Each cycle, act on ramstate:
      - ACCESS: latch ramload into dload (data read) or iload; a data write leaves dload unchanged. Go to DRESP/IRESP.
      - ERROR: go to ERR.
      - FREE or BUSY: increment the counter. If the counter equals TIMEOUT, go to ERR.
    - Changes or drops of the request inputs during the ACC states are ignored. The captured access always completes.
  - DRESP/IRESP:
    - dhit or ihit = 1 for exactly this cycle; ram enables = 0.
    - Return to IDLE.
    - The requester must deassert or change its request by the next edge. A request still held in IDLE is treated as a new access.
  - ERR:
    - merr = 1; ihit, dhit, ramREN, ramWEN = 0.
    - Remains in ERR until reset.
- Outputs ihit, dhit, iload, dload and merr are registered. iload/dload hold their last value until overwritten.
- Latency: request sampled in IDLE at edge N, ram enables asserted in cycle N+1. ramstate=ACCESS in cycle N+k produces a hit during cycle N+k+1. Minimum request-to-hit latency is 2 cycles.
- Never more than one RAM access outstanding. ramREN and ramWEN are never both 1.
- The counter is ceil(log2(TIMEOUT+1)) bits and does not wrap; it saturates at TIMEOUT and triggers ERR.

Test Plan:
- Reset with iREN=1, iaddr=0x0000_0040, RAM returning ACCESS immediately with ramload=0x2001_0005 -> ramREN=1, ramaddr=0x40 the cycle after the request. ihit pulses one cycle later with iload=0x2001_0005; dhit stays 0.
- dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF, RAM BUSY 3 cycles then ACCESS -> ramWEN=1 and ramstore=0xDEADBEEF held for 4 cycles. dhit pulses once; dload unchanged; ramREN never 1.
- iREN and dREN held high together from reset, each RAM access taking 1 cycle -> grants alternate data, instr, data, instr. Neither hit output sees two consecutive grants while both requests are pending.
- dREN dropped to 0 and daddr changed to 0x200 mid-access (addr 0x80) -> ramaddr stays 0x80 and dhit still pulses with the ramload value.
- RAM held BUSY with TIMEOUT=4 -> enters ERR after 4 waiting cycles: merr=1, all enables 0, no hits. merr stays 1 until nRST=0 at an edge clears it. Repeat with ramstate=ERROR mid-access: same response.
- nRST=0 asserted in DACC with RAM not yet in ACCESS -> next cycle all outputs at reset values and no dhit. After release, a fresh iREN is served normally.

Source files
------------

// File: rtl/memory_arbiter_ctrl.sv
// memory_arbiter_ctrl
//   Memory-side responder for the CPU request unit. It serialises instruction
//   fetches and data reads/writes onto one single-ported RAM and returns a
//   one-cycle hit pulse with the load data held in a register.
//
//   Ports
//     CLK, nRST                 clock (rising edge), synchronous active-low reset
//     iREN, iaddr               instruction read request
//     dREN, dWEN, daddr, dstore data read/write request
//     ihit, iload               instruction complete pulse, fetched word
//     dhit, dload               data complete pulse, loaded word
//     ramREN, ramWEN            RAM enables (never both high)
//     ramaddr, ramstore         RAM address / write data
//     ramload, ramstate         RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//     merr                      sticky error flag, cleared only by reset
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request, arbitrates between instr and data
//   IACC  | instruction access in flight on the RAM
//   DACC  | data access in flight on the RAM
//   IRESP | ihit pulse cycle, RAM enables off
//   DRESP | dhit pulse cycle, RAM enables off
//   ERR   | RAM error or timeout, held until reset
module memory_arbiter_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              merr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_IACC, S_DACC, S_IRESP, S_DRESP, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  store_q, store_d;
  logic               wr_q, wr_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ihit_q, ihit_d;
  logic               dhit_q, dhit_d;
  logic [DATA_W-1:0]  iload_q, iload_d;
  logic [DATA_W-1:0]  dload_q, dload_d;
  logic               merr_q, merr_d;
  logic               data_req;
  logic               grant_data;
  logic               in_acc;

  assign data_req = dREN | dWEN;
  // With both sides pending, the side that did not win last time goes next.
  assign grant_data = data_req & (~iREN | (last_q == GRANT_I));
  // The counter parks at its maximum; it never wraps back to zero.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    iload_d = iload_q;
    dload_d = dload_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          last_d  = GRANT_D;
          cnt_d   = '0;
          state_d = S_DACC;
        end else if (iREN) begin
          addr_d  = iaddr;
          wr_d    = 1'b0;
          last_d  = GRANT_I;
          cnt_d   = '0;
          state_d = S_IACC;
        end
      end
      S_IACC, S_DACC: begin
        if (ramstate == RAM_ACCESS) begin
          if (state_q == S_IACC) begin
            iload_d = ramload;
            ihit_d  = 1'b1;
            state_d = S_IRESP;
          end else begin
            if (!wr_q) dload_d = ramload;
            dhit_d  = 1'b1;
            state_d = S_DRESP;
          end
        end else if (ramstate == RAM_ERROR) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = S_ERR;
        end
      end
      S_IRESP, S_DRESP: state_d = S_IDLE;
      S_ERR:            state_d = S_ERR;
      default:          state_d = S_IDLE;
    endcase
    merr_d = merr_q | (state_d == S_ERR);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      last_q  <= GRANT_I;
      cnt_q   <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      merr_q  <= merr_d;
    end
  end

  // RAM side is driven purely from the captured request, so requester
  // changes during an access never reach the RAM.
  assign in_acc   = (state_q == S_IACC) | (state_q == S_DACC);
  assign ramREN   = in_acc & ~wr_q;
  assign ramWEN   = in_acc & wr_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;

  assign ihit  = ihit_q;
  assign dhit  = dhit_q;
  assign iload = iload_q;
  assign dload = dload_q;
  assign merr  = merr_q;

endmodule
